// File: rtl/uart_rx_byte_counter.sv
// 8N1 UART receiver that counts good bytes, holds the last good byte and
// raises a sticky flag when a stop bit is sampled low.
module uart_rx_byte_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       clear,
  output logic [7:0] byte_count,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_count_q, byte_count_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             rx_s;
  logic             good_byte;
  logic             bad_stop;

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d     = {sync_q[0], rx};
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    good_byte  = 1'b0;
    bad_stop   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // A start bit that is high again at mid-bit is a glitch.
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = 3'd0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            good_byte = 1'b1;
            state_d   = S_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (good_byte) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end

    // Clear and increment in the same cycle leave the new byte counted;
    // a stop-bit error in the same cycle as clear keeps the flag set.
    byte_count_d  = (clear ? 8'd0 : byte_count_q) + {7'd0, good_byte};
    frame_error_d = bad_stop | (frame_error_q & ~clear);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      sync_q        <= 2'b11;
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      shift_q       <= 8'd0;
      byte_count_q  <= 8'd0;
      rx_data_q     <= 8'd0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= sync_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      byte_count_q  <= byte_count_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign byte_count  = byte_count_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_rx_byte_counter.sv
// Randomized bench for uart_rx_byte_counter: serial frames are driven on rx and
// the outputs are compared with a frame-level model of count, data and flag.
module tb_uart_rx_byte_counter;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       clear;
  logic [7:0] byte_count;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_count;
  logic [7:0] m_data;
  logic       m_fe;
  logic       prev_valid = 1'b0;

  uart_rx_byte_counter #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .clear      (clear),
    .byte_count (byte_count),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Collect every rx_valid pulse with its data; pulses must never be adjacent.
  always @(negedge clk) begin
    if (reset_n !== 1'b1) begin
      prev_valid <= 1'b0;
    end else begin
      if (rx_valid === 1'b1) begin
        check_eq("valid_gap", {31'd0, prev_valid}, 32'd0);
        got_q.push_back(rx_data);
      end
      prev_valid <= rx_valid;
    end
  end

  task automatic check_state(input string tag);
    check_eq({tag, "_count"}, {24'd0, byte_count}, {24'd0, m_count});
    check_eq({tag, "_data"},  {24'd0, rx_data},    {24'd0, m_data});
    check_eq({tag, "_ferr"},  {31'd0, frame_error}, {31'd0, m_fe});
  endtask

  task automatic cmp_queues(input string tag);
    int n;
    check_eq({tag, "_npulses"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    @(negedge clk);
    m_count = 8'd0;
    m_fe    = 1'b0;
  endtask

  // Drives one frame starting at a falling clock edge. With clr_at_stop the
  // clear pulse lands on the edge where the stop-bit outcome is registered.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit clr_at_stop,
                            input int extra_low, input int gap);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    if (clr_at_stop) begin
      repeat (10) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (CPB - 11) @(negedge clk);
    end else begin
      repeat (CPB) @(negedge clk);
    end
    if (!stop) repeat (extra_low) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
    if (stop) begin
      m_count = clr_at_stop ? 8'd1 : m_count + 8'd1;
      m_data  = b;
      m_fe    = 1'b0 | (m_fe & ~clr_at_stop);
      exp_q.push_back(b);
    end else begin
      if (clr_at_stop) m_count = 8'd0;
      m_fe = 1'b1;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic       stop;

    rx      = 1'b1;
    clear   = 1'b0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_count", {24'd0, byte_count}, 32'd0);
    check_eq("rst_data",  {24'd0, rx_data},    32'd0);
    check_eq("rst_valid", {31'd0, rx_valid},   32'd0);
    check_eq("rst_ferr",  {31'd0, frame_error}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_count = 8'd0;
    m_data  = 8'd0;
    m_fe    = 1'b0;
    repeat (4) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0, 0, 8);
    check_state("a5");
    cmp_queues("a5");

    rx = 1'b0;
    repeat (5) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check_state("glitch");
    cmp_queues("glitch");

    do_clear();
    send_frame(8'h3C, 1'b0, 1'b0, 40, 8);
    check_state("break");
    send_frame(8'h11, 1'b1, 1'b0, 0, 8);
    check_state("after_break");
    cmp_queues("break");

    do_clear();
    check_state("clear_only");

    for (int i = 0; i < 7; i++) send_frame(8'($urandom), 1'b1, 1'b0, 0, 4);
    check_state("seven");
    send_frame(8'h6E, 1'b1, 1'b1, 0, 8);
    check_state("clr_inc");
    send_frame(8'h99, 1'b0, 1'b1, 10, 8);
    check_state("clr_ferr");
    cmp_queues("clr");

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) do_clear();
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      if (stop) send_frame(b, 1'b1, 1'b0, 0, $urandom_range(0, 20));
      else      send_frame(b, 1'b0, 1'b0, $urandom_range(0, 40), $urandom_range(4, 20));
      check_state("rand");
    end
    cmp_queues("rand");

    do_clear();
    for (int i = 0; i < 256; i++) send_frame(8'($urandom), 1'b1, 1'b0, 0, 0);
    repeat (8) @(negedge clk);
    check_state("wrap");
    cmp_queues("wrap");

    send_frame(8'h5A, 1'b1, 1'b0, 0, 8);
    check_state("pre_abort");
    b  = 8'hC3;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[4];
    repeat (CPB / 2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_eq("abort_count", {24'd0, byte_count}, 32'd0);
    check_eq("abort_data",  {24'd0, rx_data},    32'd0);
    check_eq("abort_valid", {31'd0, rx_valid},   32'd0);
    check_eq("abort_ferr",  {31'd0, frame_error}, 32'd0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_count = 8'd0;
    m_data  = 8'd0;
    m_fe    = 1'b0;
    repeat (CPB * 4) @(negedge clk);
    send_frame(8'h80, 1'b1, 1'b0, 0, 8);
    check_state("post_abort");
    cmp_queues("abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_byte_counter.md
UART_RX_BYTE_COUNTER -- requirements
Module: uart_rx_byte_counter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, giving clock cycles per serial bit (50 MHz / 115200); legal values 4 and above.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rx, input, 1 bit: asynchronous serial line, 8N1 framing, idles high.
REQ-005 SHALL have port clear, input, 1 bit: synchronous clear of byte_count and frame_error.
REQ-006 SHALL have port byte_count, output, 8 bits: count of good bytes received; drives the number-received-bytes PIO input.
REQ-007 SHALL have port rx_data, output, 8 bits: the last good byte received.
REQ-008 SHALL have port rx_valid, output, 1 bit: one-cycle pulse when rx_data is updated.
REQ-009 SHALL have port frame_error, output, 1 bit: sticky stop-bit error flag.

Function
REQ-010 SHALL pass rx through a two-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP and WAIT_HIGH, plus a baud counter and a 3-bit bit index.
REQ-012 IDLE: SHALL move to START with the baud counter at 0 when rx_s is 0.
REQ-013 START: SHALL sample rx_s when the baud counter reaches CLKS_PER_BIT/2 - 1 (integer division); on 0, go to DATA with counter 0 and bit index 0; on 1, treat as a glitch and return to IDLE.
REQ-014 DATA: SHALL sample rx_s each time the counter reaches CLKS_PER_BIT-1, then reset the counter; bits are shifted in LSB first; after the bit with index 7, go to STOP.
REQ-015 STOP: SHALL sample rx_s when the counter reaches CLKS_PER_BIT-1.
REQ-016 STOP sample = 1: SHALL load rx_data, pulse rx_valid, increment byte_count and go to IDLE, all on the clock edge after the sample cycle.
REQ-017 STOP sample = 0: SHALL set frame_error, leave rx_data and byte_count unchanged, not pulse rx_valid, and go to WAIT_HIGH.
REQ-018 WAIT_HIGH: SHALL stay until rx_s is 1, then go to IDLE, so that a break condition is not counted.
REQ-019 byte_count SHALL be modulo 256: 255 + 1 wraps to 0 with no flag.
REQ-020 clear SHALL set byte_count to 0 and frame_error to 0 on the next edge; it does not affect the FSM or rx_data.
REQ-021 clear in the same cycle as a good-byte increment SHALL give byte_count = 1, so the byte is not lost.
REQ-022 clear in the same cycle as a frame-error set SHALL leave frame_error = 1 (set wins).
REQ-023 rx_valid SHALL never be high for two consecutive cycles.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 reset_n low SHALL immediately set the following, independent of clk: state IDLE, counters 0, synchronizer flops 1, byte_count 0, rx_data 0, rx_valid 0, frame_error 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no count and no rx_valid pulse; after release, reception restarts on the next start bit.

Verification
REQ-027 CLKS_PER_BIT=16, frame 0xA5 with stop bit 1 -> exactly one rx_valid pulse; rx_data=0xA5; byte_count 0->1.
REQ-028 256 back-to-back good frames -> byte_count returns to 0; 256 rx_valid pulses.
REQ-029 Frame 0x3C with stop bit 0, line held low 40 cycles, then high; then good frame 0x11 -> frame_error=1; rx_data=0x11; byte_count=1.
REQ-030 rx low pulse of 5 cycles (shorter than CLKS_PER_BIT/2) -> no rx_valid; state back to IDLE; byte_count unchanged.
REQ-031 byte_count=7; clear asserted in the rx_valid cycle -> byte_count=1. Separately, clear alone -> byte_count=0 and frame_error=0.
REQ-032 reset_n pulsed low during DATA bit 4 -> all outputs 0 immediately; the next full frame 0x80 -> byte_count=1, rx_data=0x80.
